// File: rtl/uart_rx_sipo.sv
// UART receiver: 2-flop synchronised rx, start-bit validation at mid-bit,
// 8 data bits LSB first, optional parity, one stop bit, break hold-off.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       parity_rx,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active_flag
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             par_s;

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      par_s       <= 1'b0;
      data_out    <= '0;
      parity_rx   <= 1'b0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      active_flag <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state       <= S_START;
            cnt         <= '0;
            active_flag <= 1'b1;
          end
        end

        // A start bit that is high again at its centre was a glitch.
        S_START: begin
          if (cnt == CNT_HALF) begin
            if (!rx_s) begin
              state   <= S_DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end else begin
              state       <= S_IDLE;
              active_flag <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt == CNT_FULL) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            cnt       <= '0;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= PAR_EN ? S_PARITY : S_STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (cnt == CNT_FULL) begin
            par_s <= rx_s;
            cnt   <= '0;
            state <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // A low stop sample is a framing error; a line still low is a break.
        S_STOP: begin
          if (cnt == CNT_FULL) begin
            data_out   <= shift_reg;
            parity_rx  <= par_s & PAR_EN;
            parity_err <= PAR_EN & (^shift_reg ^ par_s ^ PAR_ODD);
            frame_err  <= ~rx_s;
            rx_valid   <= 1'b1;
            cnt        <= '0;
            if (rx_s) begin
              state       <= S_IDLE;
              active_flag <= 1'b0;
            end else begin
              state <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state       <= S_IDLE;
            active_flag <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule
